fifo_128_wr_arbiter: RTL and testbench

// Packet-granular round-robin arbiter that lets two 128-bit producers share the

---
 rtl/fifo_128_wr_arbiter_if.sv | 14 +
 rtl/fifo_128_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_128_wr_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_128_wr_arbiter_if.sv
// Producer-side beat stream: valid/ready handshake carrying data and end-of-packet.
// Latency: none (wires only).
// Backpressure: the producer holds valid/data/last until it samples ready high.
interface fifo_128_wr_arbiter_if #(
  parameter int DW = 128
);
  logic          valid;
  logic [DW-1:0] data;
  logic          last;
  logic          ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_128_wr_arbiter.sv
// Packet-granular round-robin arbiter merging two producers onto one FIFO write port.
// Latency: accepted beat appears on fifo_wr_en/fifo_din exactly 1 cycle later; 1 idle cycle per grant.
// Backpressure: granted port's ready = ~(prog_full | full); the other port's ready stays low.
module fifo_128_wr_arbiter #(
  parameter int DW        = 128,
  parameter int MAX_BEATS = 64,
  parameter int CW        = 7     // 2**CW must exceed MAX_BEATS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fifo_128_wr_arbiter_if.slave    s0,
  fifo_128_wr_arbiter_if.slave    s1,
  input  logic                    fifo_prog_full,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DW-1:0]           fifo_din,
  output logic [1:0]              gnt,
  output logic                    err_len
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Counter value held while the MAX_BEATS-th beat of a packet is presented.
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          rr_q, rr_d;       // 1: port 1 wins a tie, 0: port 0 wins
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;

  logic          stall;
  logic          rdy0, rdy1;
  logic          acc;
  logic          sel_last;
  logic [DW-1:0] sel_data;
  logic          at_max;

  assign stall    = fifo_prog_full | fifo_full;
  assign s0.ready = rdy0;
  assign s1.ready = rdy1;
  assign gnt      = gnt_q;

  // State register: FSM state, grant, round-robin pointer, beat counter, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      err_len <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_len <= err_d;
    end
  end

  // Next-state: arbitrate in IDLE, close the packet on last or when the length cap is hit.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_len;
    case (state_q)
      IDLE: begin
        if (s0.valid && (!s1.valid || !rr_q)) begin
          state_d = BUSY;
          gnt_d   = 2'b01;
        end else if (s1.valid) begin
          state_d = BUSY;
          gnt_d   = 2'b10;
        end
      end
      BUSY: begin
        if (acc) begin
          if (sel_last || at_max) begin
            // A capped packet ends here too; its tail re-arbitrates as a fresh packet.
            state_d = IDLE;
            gnt_d   = 2'b00;
            rr_d    = gnt_q[0];
            cnt_d   = '0;
            if (!sel_last) err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Outputs: ready depends only on registered grant and FIFO flags, never on valid.
  always_comb begin
    rdy0     = (state_q == BUSY) && gnt_q[0] && !stall;
    rdy1     = (state_q == BUSY) && gnt_q[1] && !stall;
    acc      = (s0.valid && rdy0) || (s1.valid && rdy1);
    sel_last = gnt_q[1] ? s1.last : s0.last;
    sel_data = gnt_q[1] ? s1.data : s0.data;
    at_max   = (cnt_q == LAST_CNT);
  end

  // Write register toward the FIFO; data holds between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= acc;
      if (acc) fifo_din <= sel_data;
    end
  end

endmodule

// File: tb/tb_fifo_128_wr_arbiter.sv
// Directed bench for fifo_128_wr_arbiter: queue-driven producers, write/accept logging monitor.
// Latency: expected FIFO writes land 1 cycle after each accept.
// Backpressure: producers hold a beat until it is accepted.
module tb_fifo_128_wr_arbiter;
  localparam int DW = 128;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          fifo_prog_full;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic [1:0]    gnt;
  logic          err_len;

  fifo_128_wr_arbiter_if #(.DW(DW)) s0_if ();
  fifo_128_wr_arbiter_if #(.DW(DW)) s1_if ();

  fifo_128_wr_arbiter #(.DW(DW), .MAX_BEATS(64), .CW(7)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s0             (s0_if),
    .s1             (s1_if),
    .fifo_prog_full (fifo_prog_full),
    .fifo_full      (fifo_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .gnt            (gnt),
    .err_len        (err_len)
  );

  int tests = 0;
  int fails = 0;

  beat_t         q0[$];
  beat_t         q1[$];
  int            acc_port[$];
  int            acc_cyc[$];
  logic [DW-1:0] wq[$];
  int            wt[$];
  int            cyc;
  int            lat_err;
  int            err_first;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] mk(input int p, input int k);
    mk = (DW'(p) << 16) | DW'(k);
  endfunction

  task automatic push0(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q0.push_back(b);
  endtask

  task automatic push1(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q1.push_back(b);
  endtask

  // Producer 0: presents the queue head, pops it once seen accepted.
  initial begin : prod0
    bit a;
    s0_if.valid = 1'b0;
    s0_if.data  = '0;
    s0_if.last  = 1'b0;
    forever begin
      @(negedge clk);
      a = s0_if.valid & s0_if.ready;
      @(posedge clk);
      #1;
      if (a && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        s0_if.valid = 1'b1;
        s0_if.data  = q0[0].d;
        s0_if.last  = q0[0].l;
      end else begin
        s0_if.valid = 1'b0;
      end
    end
  end

  // Producer 1: same behaviour on port 1.
  initial begin : prod1
    bit a;
    s1_if.valid = 1'b0;
    s1_if.data  = '0;
    s1_if.last  = 1'b0;
    forever begin
      @(negedge clk);
      a = s1_if.valid & s1_if.ready;
      @(posedge clk);
      #1;
      if (a && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        s1_if.valid = 1'b1;
        s1_if.data  = q1[0].d;
        s1_if.last  = q1[0].l;
      end else begin
        s1_if.valid = 1'b0;
      end
    end
  end

  // Monitor: logs accepts and writes, tallies latency/one-hot violations, notes first err_len cycle.
  initial begin : mon
    bit            a0, a1, prev_acc;
    logic [DW-1:0] prev_dat;
    cyc       = 0;
    lat_err   = 0;
    err_first = -1;
    prev_acc  = 1'b0;
    prev_dat  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      a0 = s0_if.valid & s0_if.ready;
      a1 = s1_if.valid & s1_if.ready;
      if (rst_n) begin
        if (fifo_wr_en !== prev_acc) lat_err++;
        else if (prev_acc && fifo_din !== prev_dat) lat_err++;
        if (a0 && a1) lat_err++;
        if (fifo_wr_en) begin
          wq.push_back(fifo_din);
          wt.push_back(cyc);
        end
      end
      if (a0) begin
        acc_port.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (a1) begin
        acc_port.push_back(1);
        acc_cyc.push_back(cyc);
      end
      prev_acc = a0 | a1;
      prev_dat = a1 ? s1_if.data : s0_if.data;
      if (!err_len) err_first = -1;
      else if (err_first < 0) err_first = cyc;
    end
  end

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (wq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_accepts(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (acc_port.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_prog_full = 1'b0;
    fifo_full = 1'b0;
    q0.delete();
    q1.delete();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fifo_prog_full = 1'b0;
    fifo_full = 1'b0;
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b need 00", gnt); end
    tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b need 0", fifo_wr_en); end
    tests++; if (fifo_din !== '0) begin fails++; $display("FAIL reset_din: got %h need 0", fifo_din); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL reset_err: got %b need 0", err_len); end
    tests++; if ({s1_if.ready, s0_if.ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b need 00", {s1_if.ready, s0_if.ready}); end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (gnt !== 2'b00 || fifo_wr_en !== 1'b0) begin fails++; $display("FAIL idle_after_reset: got gnt=%b wr_en=%b need 00/0", gnt, fifo_wr_en); end
  endtask

  task automatic test_single_port();
    int b, ab, nz;
    bit ok;
    b = wq.size();
    ab = acc_port.size();
    @(negedge clk);
    for (int i = 0; i < 12; i++) push0(mk(0, i), (i % 4) == 3);
    wait_writes(b + 12, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL sp_timeout: got %0d writes need 12", wq.size() - b); end
    if (ok) begin
      for (int i = 0; i < 12; i++) begin
        tests++; if (wq[b+i] !== mk(0, i)) begin fails++; $display("FAIL sp_data[%0d]: got %h need %h", i, wq[b+i], mk(0, i)); end
      end
      for (int i = 1; i < 12; i++) begin
        tests++; if (wt[b+i] - wt[b+i-1] !== ((i % 4 == 0) ? 2 : 1)) begin
          fails++; $display("FAIL sp_gap[%0d]: got %0d need %0d", i, wt[b+i] - wt[b+i-1], (i % 4 == 0) ? 2 : 1);
        end
      end
    end
    nz = 0;
    for (int i = ab; i < acc_port.size(); i++) if (acc_port[i] != 0) nz++;
    tests++; if (nz !== 0) begin fails++; $display("FAIL sp_port: got %0d port1 accepts need 0", nz); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL sp_err: got %b need 0", err_len); end
    tests++; if (lat_err !== 0) begin fails++; $display("FAIL sp_latency: got %0d violations need 0", lat_err); end
  endtask

  task automatic test_two_ports();
    int b, p, k;
    bit ok;
    do_reset();
    b = wq.size();
    for (int pk = 0; pk < 3; pk++) begin
      push0(mk(0, pk * 2), 1'b0);
      push0(mk(0, pk * 2 + 1), 1'b1);
      push1(mk(1, pk * 2), 1'b0);
      push1(mk(1, pk * 2 + 1), 1'b1);
    end
    wait_writes(b + 12, 300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL tp_timeout: got %0d writes need 12", wq.size() - b); end
    if (ok) begin
      for (int i = 0; i < 12; i++) begin
        p = (i % 4) / 2;
        k = (i / 4) * 2 + (i % 2);
        tests++; if (wq[b+i] !== mk(p, k)) begin fails++; $display("FAIL tp_order[%0d]: got %h need %h", i, wq[b+i], mk(p, k)); end
      end
    end
    tests++; if (lat_err !== 0) begin fails++; $display("FAIL tp_latency: got %0d violations need 0", lat_err); end
  endtask

  task automatic test_stall();
    int b, ab, hi, gbad, frozen;
    bit ok;
    b = wq.size();
    ab = acc_port.size();
    @(negedge clk);
    for (int i = 0; i < 6; i++) push0(mk(0, 100 + i), i == 5);
    wait_accepts(ab + 2, 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL st_start: got %0d accepts need 2", acc_port.size() - ab); end
    @(posedge clk);
    #1;
    fifo_prog_full = 1'b1;
    frozen = acc_port.size();
    hi = 0;
    gbad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s0_if.ready) hi++;
      if (gnt !== 2'b01) gbad++;
    end
    @(posedge clk);
    #1;
    fifo_prog_full = 1'b0;
    tests++; if (hi !== 0) begin fails++; $display("FAIL st_ready: got %0d ready cycles need 0", hi); end
    tests++; if (gbad !== 0) begin fails++; $display("FAIL st_gnt_held: got %0d bad cycles need 0", gbad); end
    tests++; if (acc_port.size() !== frozen) begin fails++; $display("FAIL st_frozen: got %0d accepts need %0d", acc_port.size(), frozen); end
    wait_accepts(ab + 4, 100, ok);
    @(posedge clk);
    #1;
    fifo_full = 1'b1;
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (s0_if.ready) hi++;
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    tests++; if (hi !== 0) begin fails++; $display("FAIL st_full_ready: got %0d ready cycles need 0", hi); end
    wait_writes(b + 6, 100, ok);
    repeat (5) @(negedge clk);
    tests++; if (wq.size() !== b + 6) begin fails++; $display("FAIL st_count: got %0d writes need 6", wq.size() - b); end
    if (wq.size() >= b + 6) begin
      for (int i = 0; i < 6; i++) begin
        tests++; if (wq[b+i] !== mk(0, 100 + i)) begin fails++; $display("FAIL st_data[%0d]: got %h need %h", i, wq[b+i], mk(0, 100 + i)); end
      end
    end
    tests++; if (lat_err !== 0) begin fails++; $display("FAIL st_latency: got %0d violations need 0", lat_err); end
  endtask

  task automatic test_overlen();
    int b, ab;
    bit ok;
    logic [DW-1:0] e;
    do_reset();
    b = wq.size();
    for (int i = 0; i < 64; i++) push1(mk(1, i), i == 63);
    wait_writes(b + 64, 300, ok);
    repeat (3) @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL ol_legal_timeout: got %0d writes need 64", wq.size() - b); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL ol_legal_err: got %b need 0", err_len); end

    b = wq.size();
    ab = acc_port.size();
    for (int i = 0; i < 70; i++) push1(mk(1, 200 + i), i == 69);
    wait_accepts(ab + 1, 50, ok);
    push0(mk(0, 300), 1'b0);
    push0(mk(0, 301), 1'b1);
    wait_writes(b + 72, 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ol_timeout: got %0d writes need 72", wq.size() - b); end
    if (ok) begin
      for (int i = 0; i < 72; i++) begin
        if (i < 64) e = mk(1, 200 + i);
        else if (i < 66) e = mk(0, 300 + i - 64);
        else e = mk(1, 200 + 64 + i - 66);
        tests++; if (wq[b+i] !== e) begin fails++; $display("FAIL ol_order[%0d]: got %h need %h", i, wq[b+i], e); end
      end
      tests++; if (err_first !== acc_cyc[ab+63] + 1) begin
        fails++; $display("FAIL ol_err_cycle: got %0d need %0d", err_first, acc_cyc[ab+63] + 1);
      end
    end
    repeat (10) @(negedge clk);
    tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL ol_err_sticky: got %b need 1", err_len); end
    tests++; if (lat_err !== 0) begin fails++; $display("FAIL ol_latency: got %0d violations need 0", lat_err); end
  endtask

  task automatic test_async_reset();
    int b, ab;
    bit ok;
    ab = acc_port.size();
    @(negedge clk);
    for (int i = 0; i < 8; i++) push0(mk(0, 400 + i), i == 7);
    wait_accepts(ab + 3, 100, ok);
    @(posedge clk);
    #3;
    tests++; if (fifo_wr_en !== 1'b1) begin fails++; $display("FAIL ar_pre_wr_en: got %b need 1", fifo_wr_en); end
    rst_n = 1'b0;
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL ar_gnt: got %b need 00", gnt); end
    tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL ar_wr_en: got %b need 0", fifo_wr_en); end
    tests++; if ({s1_if.ready, s0_if.ready} !== 2'b00) begin fails++; $display("FAIL ar_ready: got %b need 00", {s1_if.ready, s0_if.ready}); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL ar_err: got %b need 0", err_len); end
    q0.delete();
    q1.delete();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b = wq.size();
    ab = acc_port.size();
    push0(mk(0, 500), 1'b1);
    push1(mk(1, 500), 1'b1);
    wait_writes(b + 2, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ar_restart_timeout: got %0d writes need 2", wq.size() - b); end
    if (ok) begin
      tests++; if (acc_port[ab] !== 0) begin fails++; $display("FAIL ar_restart_port: got %0d need 0", acc_port[ab]); end
      tests++; if (wq[b] !== mk(0, 500)) begin fails++; $display("FAIL ar_restart_data: got %h need %h", wq[b], mk(0, 500)); end
    end
  endtask

  task automatic test_single_beat();
    int b, ab, bad;
    bit ok;
    do_reset();
    b = wq.size();
    ab = acc_port.size();
    for (int i = 0; i < 4; i++) begin
      push0(mk(0, 600 + i), 1'b1);
      push1(mk(1, 600 + i), 1'b1);
    end
    wait_writes(b + 8, 100, ok);
    repeat (5) @(negedge clk);
    tests++; if (wq.size() !== b + 8) begin fails++; $display("FAIL sb_count: got %0d writes need 8", wq.size() - b); end
    if (ok) begin
      bad = 0;
      for (int i = 0; i < 8; i++) if (acc_port[ab+i] != (i % 2)) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL sb_alternation: got %0d out-of-turn grants need 0", bad); end
      for (int i = 0; i < 8; i++) begin
        tests++; if (wq[b+i] !== mk(i % 2, 600 + i / 2)) begin fails++; $display("FAIL sb_data[%0d]: got %h need %h", i, wq[b+i], mk(i % 2, 600 + i / 2)); end
      end
    end
    tests++; if (lat_err !== 0) begin fails++; $display("FAIL sb_latency: got %0d violations need 0", lat_err); end
  endtask

  initial begin : main
    test_reset();
    test_single_port();
    test_two_ports();
    test_stall();
    test_overlen();
    test_async_reset();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
